reward_sprite_engine: RTL and testbench
=======================================

REWARD_SPRITE_ENGINE -- requirements
Module: reward_sprite_engine

Interface
REQ-001 Parameter CELL, default 20: grid cell pitch in pixels.
REQ-002 Parameter ORIGIN, default 80: pixel offset of grid cell 0 centre, both axes.
REQ-003 Parameter SPR, default 24: sprite edge in pixels, even; sprite is SPR x SPR.
REQ-004 Parameter AW, default 10: ROM address width; SHALL satisfy 2^AW >= SPR*SPR.
REQ-005 Parameter LIFE, default 600: reward lifetime in frames, > BLINK.
REQ-006 Parameter BLINK, default 180: final frames of lifetime spent blinking.
REQ-007 Parameter HALF, default 8: frames per blink half-period.
REQ-008 clk  in  1  single clock; all logic rises on posedge clk.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 frame_tick  in  1  one-cycle pulse per video frame.
REQ-011 place_req  in  1  one-cycle pulse: place reward at cell_x/cell_y of reward_type.
REQ-012 cell_x, cell_y  in  5 each  grid cell coordinates, sampled on place_req.
REQ-013 reward_type  in  3  1..4 valid; sampled on place_req.
REQ-014 infinity_mode  in  1  selects addtime sprite for type 1; sampled on place_req.
REQ-015 collect  in  1  one-cycle pulse: player picked reward up.
REQ-016 VGA_xpos, VGA_ypos  in  11 each  current pixel coordinates.
REQ-017 rom_addr  out  AW  sprite ROM address; rom_sel  out  3  sprite index.
REQ-018 rom_dout  in  1  sprite pixel; valid exactly 1 cycle after rom_addr/rom_sel.
REQ-019 VGA_data  out  12  RGB444 pixel; 0 when not drawing.
REQ-020 active  out  1  high in SHOW or BLINK; expired, collected  out  1 each  one-cycle pulses.

Function
REQ-021 States IDLE, SHOW, BLINK; encoding free.
REQ-022 place_req with reward_type in 1..4, any state: latch cell, type, sprite index; clear frame counter; enter SHOW.
REQ-023 place_req with reward_type 0 or 5..7: ignored, no state/latch change.
REQ-024 Sprite index: type1 -> 1 (protect) or 5 (addtime) if infinity_mode; type2 -> 2; type3 -> 3; type4 -> 4.
REQ-025 Frame counter increments on frame_tick in SHOW/BLINK; SHOW -> BLINK when counter reaches LIFE-BLINK.
REQ-026 BLINK: visibility bit starts 1 on entry, toggles every HALF frame_ticks.
REQ-027 BLINK -> IDLE when counter reaches LIFE; expired pulses 1 cycle coincident with transition.
REQ-028 collect in SHOW/BLINK -> IDLE, collected pulses 1 cycle; collect in IDLE ignored.
REQ-029 Simultaneous place_req(valid) and collect: place wins, no collected pulse; simultaneous place_req and expiry: place wins, no expired pulse.
REQ-030 Centre cx = cell_x*CELL+ORIGIN, cy likewise, computed at >=11 bits, no truncation.
REQ-031 Hit when cx-SPR/2 < VGA_xpos <= cx+SPR/2 and same for y, and state is SHOW or BLINK-visible.
REQ-032 dx = VGA_xpos-(cx-SPR/2)-1, dy likewise, each 0..SPR-1; rom_addr = dx + SPR*dy, registered stage 1.
REQ-033 Stage 1 registers rom_addr, rom_sel, hit, colour; stage 2: VGA_data = colour if hit_d1 and rom_dout else 0.
REQ-034 Total latency VGA_xpos/VGA_ypos -> VGA_data = 2 cycles; rom_addr holds 0 when not hit.
REQ-035 Colour by type: 1 -> 12'hFFF, 2 -> 12'h0F0, 3 -> 12'h0FF, 4 -> 12'hF00.
REQ-036 Re-place while active: new position/type affect pixels from the cycle after place_req onward.

Reset
REQ-037 rst high at posedge: state IDLE, counter 0, visibility 1, latches 0, rom_addr 0, rom_sel 0, VGA_data 0, active/expired/collected 0.
REQ-038 rst dominates place_req, collect, frame_tick in the same cycle; reset mid-BLINK gives IDLE with no expired pulse.

Verification
REQ-039 place_req cell (0,0) type 2; pixel (69,69) -> rom_addr 0, rom_sel 2; rom_dout=1 -> VGA_data 12'h0F0 two cycles later; pixel (68,69) -> 0.
REQ-040 Pixel (92,92) with cell (0,0) -> rom_addr 575; pixel (93,92) -> no hit, VGA_data 0.
REQ-041 Type 1 with infinity_mode=1 -> rom_sel 5, colour 12'hFFF; type 6 place_req -> state unchanged.
REQ-042 LIFE=10, BLINK=4, HALF=1: BLINK after 6 ticks, visibility 1,0,1,0, expired on 10th tick, active low next cycle.
REQ-043 collect and valid place_req same cycle in SHOW -> SHOW, counter 0, collected stays 0.
REQ-044 rst asserted in BLINK with hit pixel -> VGA_data 0 and active 0 next cycle, no expired pulse.

Source files
------------

// File: rtl/reward_sprite_engine.sv
// Reward pickup sprite: placement, lifetime/blink FSM and a two-stage pixel pipeline
// that addresses an external sprite ROM and produces RGB444 output.
module reward_sprite_engine #(
    parameter int unsigned CELL   = 20,
    parameter int unsigned ORIGIN = 80,
    parameter int unsigned SPR    = 24,
    parameter int unsigned AW     = 10,
    parameter int unsigned LIFE   = 600,
    parameter int unsigned BLINK  = 180,
    parameter int unsigned HALF   = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_frame_tick,
    input  logic          i_place_req,
    input  logic [4:0]    i_cell_x,
    input  logic [4:0]    i_cell_y,
    input  logic [2:0]    i_reward_type,
    input  logic          i_infinity_mode,
    input  logic          i_collect,
    input  logic [10:0]   i_vga_xpos,
    input  logic [10:0]   i_vga_ypos,
    output logic [AW-1:0] o_rom_addr,
    output logic [2:0]    o_rom_sel,
    input  logic          i_rom_dout,
    output logic [11:0]   o_vga_data,
    output logic          o_active,
    output logic          o_expired,
    output logic          o_collected
);

    localparam int unsigned CW  = $clog2(LIFE + 1);
    localparam int unsigned HCW = $clog2(HALF + 1);
    localparam int unsigned PW  = 14;
    localparam int unsigned HS  = SPR / 2;

    typedef enum logic [1:0] {StIdle, StShow, StBlink} state_e;

    state_e           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [HCW-1:0]   r_half, w_half_nxt;
    logic             r_vis, w_vis_nxt;
    logic             w_expired, w_collected, w_place_ok;

    logic [4:0]       r_cell_x, r_cell_y;
    logic [2:0]       r_type, r_sel, w_sel;

    logic [PW-1:0]    w_cx, w_cy, w_xp, w_yp, w_dx, w_dy, w_addr_full;
    logic             w_hit_x, w_hit_y, w_draw, w_hit;
    logic [AW-1:0]    w_rom_addr;
    logic [11:0]      w_colour;

    logic [AW-1:0]    r_rom_addr;
    logic [2:0]       r_rom_sel;
    logic             r_hit;
    logic [11:0]      r_colour;
    logic [11:0]      r_vga;

    assign w_place_ok = i_place_req && (i_reward_type >= 3'd1) && (i_reward_type <= 3'd4);
    assign w_sel      = (i_reward_type == 3'd1 && i_infinity_mode) ? 3'd5 : i_reward_type;
    assign w_cnt_inc  = r_cnt + CW'(1);

    // Priority: place > collect > frame tick; reset is applied in the state register.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_half_nxt  = r_half;
        w_vis_nxt   = r_vis;
        w_expired   = 1'b0;
        w_collected = 1'b0;
        if (w_place_ok) begin
            w_state_nxt = StShow;
            w_cnt_nxt   = '0;
            w_half_nxt  = '0;
            w_vis_nxt   = 1'b1;
        end else if (i_collect && r_state != StIdle) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
            w_half_nxt  = '0;
            w_vis_nxt   = 1'b1;
            w_collected = 1'b1;
        end else if (i_frame_tick && r_state != StIdle) begin
            w_cnt_nxt = w_cnt_inc;
            if (r_state == StShow) begin
                if (w_cnt_inc == CW'(LIFE - BLINK)) begin
                    w_state_nxt = StBlink;
                    w_half_nxt  = '0;
                    w_vis_nxt   = 1'b1;
                end
            end else if (w_cnt_inc == CW'(LIFE)) begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
                w_half_nxt  = '0;
                w_vis_nxt   = 1'b1;
                w_expired   = 1'b1;
            end else if (r_half == HCW'(HALF - 1)) begin
                w_half_nxt = '0;
                w_vis_nxt  = ~r_vis;
            end else begin
                w_half_nxt = r_half + HCW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_half   <= '0;
            r_vis    <= 1'b1;
            r_cell_x <= '0;
            r_cell_y <= '0;
            r_type   <= '0;
            r_sel    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_half  <= w_half_nxt;
            r_vis   <= w_vis_nxt;
            if (w_place_ok) begin
                r_cell_x <= i_cell_x;
                r_cell_y <= i_cell_y;
                r_type   <= i_reward_type;
                r_sel    <= w_sel;
            end
        end
    end

    // Window test written as additions so cx - SPR/2 never underflows.
    always_comb begin
        w_cx        = PW'(r_cell_x) * PW'(CELL) + PW'(ORIGIN);
        w_cy        = PW'(r_cell_y) * PW'(CELL) + PW'(ORIGIN);
        w_xp        = PW'(i_vga_xpos);
        w_yp        = PW'(i_vga_ypos);
        w_hit_x     = (w_xp + PW'(HS) > w_cx) && (w_xp <= w_cx + PW'(HS));
        w_hit_y     = (w_yp + PW'(HS) > w_cy) && (w_yp <= w_cy + PW'(HS));
        w_dx        = w_xp + PW'(HS) - w_cx - PW'(1);
        w_dy        = w_yp + PW'(HS) - w_cy - PW'(1);
        w_addr_full = w_dx + PW'(SPR) * w_dy;
        w_draw      = (r_state == StShow) || (r_state == StBlink && r_vis);
        w_hit       = w_draw && w_hit_x && w_hit_y;
        w_rom_addr  = w_hit ? AW'(w_addr_full) : '0;
    end

    always_comb begin
        w_colour = '0;
        case (r_type)
            3'd1:    w_colour = 12'hFFF;
            3'd2:    w_colour = 12'h0F0;
            3'd3:    w_colour = 12'h0FF;
            3'd4:    w_colour = 12'hF00;
            default: w_colour = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rom_addr <= '0;
            r_rom_sel  <= '0;
            r_hit      <= 1'b0;
            r_colour   <= '0;
            r_vga      <= '0;
        end else begin
            r_rom_addr <= w_rom_addr;
            r_rom_sel  <= r_sel;
            r_hit      <= w_hit;
            r_colour   <= w_colour;
            r_vga      <= (r_hit && i_rom_dout) ? r_colour : 12'h000;
        end
    end

    assign o_rom_addr  = r_rom_addr;
    assign o_rom_sel   = r_rom_sel;
    assign o_vga_data  = r_vga;
    assign o_active    = (r_state != StIdle);
    assign o_expired   = w_expired && !i_rst;
    assign o_collected = w_collected && !i_rst;

endmodule

// File: tb/tb_reward_sprite_engine.sv
// Directed bench for reward_sprite_engine with a short lifetime (LIFE=10, BLINK=4, HALF=1).
module tb_reward_sprite_engine;

    logic        clk = 1'b0;
    logic        rst, frame_tick, place_req, infinity_mode, collect, rom_dout;
    logic [4:0]  cell_x, cell_y;
    logic [2:0]  reward_type;
    logic [10:0] xpos, ypos;
    logic [9:0]  rom_addr;
    logic [2:0]  rom_sel;
    logic [11:0] vga_data;
    logic        active, expired, collected;

    int n_cmp  = 0;
    int n_fail = 0;

    reward_sprite_engine #(
        .CELL(20), .ORIGIN(80), .SPR(24), .AW(10), .LIFE(10), .BLINK(4), .HALF(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_frame_tick(frame_tick), .i_place_req(place_req),
        .i_cell_x(cell_x), .i_cell_y(cell_y), .i_reward_type(reward_type),
        .i_infinity_mode(infinity_mode), .i_collect(collect),
        .i_vga_xpos(xpos), .i_vga_ypos(ypos), .o_rom_addr(rom_addr), .o_rom_sel(rom_sel),
        .i_rom_dout(rom_dout), .o_vga_data(vga_data), .o_active(active),
        .o_expired(expired), .o_collected(collected)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic place(input logic [2:0] t, input logic [4:0] x, input logic [4:0] y,
                         input logic inf);
        place_req = 1'b1; reward_type = t; cell_x = x; cell_y = y; infinity_mode = inf;
        step();
        place_req = 1'b0; infinity_mode = 1'b0;
    endtask

    task automatic tick_then_addr(input string tag, input logic [31:0] exp_addr);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        chk(tag, {22'd0, rom_addr}, exp_addr);
    endtask

    logic [31:0] exp_life  [9] = '{1, 1, 1, 1, 1, 1, 0, 1, 0};

    initial begin
        rst = 1'b1; frame_tick = 1'b0; place_req = 1'b0; infinity_mode = 1'b0;
        collect = 1'b0; rom_dout = 1'b0; cell_x = '0; cell_y = '0; reward_type = '0;
        xpos = '0; ypos = '0;
        step(); step();
        chk("rst_active", {31'd0, active}, 0);
        chk("rst_rom_addr", {22'd0, rom_addr}, 0);
        chk("rst_rom_sel", {29'd0, rom_sel}, 0);
        chk("rst_vga", {20'd0, vga_data}, 0);
        chk("rst_expired", {31'd0, expired}, 0);
        chk("rst_collected", {31'd0, collected}, 0);
        rst = 1'b0;

        // Top-left corner pixel of cell (0,0), type 2
        xpos = 11'd69; ypos = 11'd69; rom_dout = 1'b1;
        place(3'd2, 5'd0, 5'd0, 1'b0);
        chk("place_active", {31'd0, active}, 1);
        step();
        chk("corner_addr", {22'd0, rom_addr}, 0);
        chk("corner_sel", {29'd0, rom_sel}, 2);
        step();
        chk("corner_vga", {20'd0, vga_data}, 32'h0F0);
        xpos = 11'd68;
        step();
        chk("left_miss_addr", {22'd0, rom_addr}, 0);
        step();
        chk("left_miss_vga", {20'd0, vga_data}, 0);

        // Bottom-right corner and just outside it
        xpos = 11'd92; ypos = 11'd92;
        step();
        chk("br_addr", {22'd0, rom_addr}, 575);
        step();
        chk("br_vga", {20'd0, vga_data}, 32'h0F0);
        xpos = 11'd93;
        step();
        chk("right_miss_addr", {22'd0, rom_addr}, 0);
        step();
        chk("right_miss_vga", {20'd0, vga_data}, 0);

        // Type 1 addtime sprite at cell (1,2): centre (100,120), pixel (95,110) -> 6 + 24
        xpos = 11'd95; ypos = 11'd110;
        place(3'd1, 5'd1, 5'd2, 1'b1);
        step();
        chk("inf_addr", {22'd0, rom_addr}, 30);
        chk("inf_sel", {29'd0, rom_sel}, 5);
        step();
        chk("inf_vga", {20'd0, vga_data}, 32'hFFF);
        place(3'd6, 5'd0, 5'd0, 1'b0);
        step();
        chk("type6_addr", {22'd0, rom_addr}, 30);
        chk("type6_sel", {29'd0, rom_sel}, 5);
        place(3'd0, 5'd0, 5'd0, 1'b0);
        step();
        chk("type0_addr", {22'd0, rom_addr}, 30);

        // Lifetime: pixel (70,69) of cell (0,0) -> address 1 while visible
        xpos = 11'd70; ypos = 11'd69;
        place(3'd3, 5'd0, 5'd0, 1'b0);
        step();
        chk("life_start_addr", {22'd0, rom_addr}, 1);
        step();
        chk("type3_vga", {20'd0, vga_data}, 32'h0FF);
        for (int k = 0; k < 9; k++) begin
            tick_then_addr($sformatf("life_tick%0d_addr", k + 1), exp_life[k]);
        end
        frame_tick = 1'b1;
        #1;
        chk("expire_pulse", {31'd0, expired}, 1);
        step();
        frame_tick = 1'b0;
        chk("expire_active", {31'd0, active}, 0);
        chk("expire_pulse_end", {31'd0, expired}, 0);

        // Collect: ignored in idle, honoured in show
        collect = 1'b1;
        #1;
        chk("idle_collect", {31'd0, collected}, 0);
        step();
        collect = 1'b0;
        place(3'd4, 5'd0, 5'd0, 1'b0);
        step(); step();
        chk("type4_vga", {20'd0, vga_data}, 32'hF00);
        collect = 1'b1;
        #1;
        chk("collect_pulse", {31'd0, collected}, 1);
        step();
        collect = 1'b0;
        chk("collect_active", {31'd0, active}, 0);

        // Place and collect together after two ticks: place wins and the counter restarts
        place(3'd2, 5'd0, 5'd0, 1'b0);
        frame_tick = 1'b1; step(); step(); frame_tick = 1'b0;
        place_req = 1'b1; collect = 1'b1; reward_type = 3'd2;
        #1;
        chk("place_collect_pulse", {31'd0, collected}, 0);
        step();
        place_req = 1'b0; collect = 1'b0;
        chk("place_collect_active", {31'd0, active}, 1);
        for (int k = 0; k < 7; k++) begin
            tick_then_addr($sformatf("restart_tick%0d_addr", k + 1), exp_life[k]);
        end

        // Reset in blink with a visible hit pixel
        tick_then_addr("blink_vis_addr", 1);
        step();
        chk("blink_vga", {20'd0, vga_data}, 32'h0F0);
        rst = 1'b1; frame_tick = 1'b1;
        step();
        rst = 1'b0; frame_tick = 1'b0;
        chk("blink_rst_active", {31'd0, active}, 0);
        chk("blink_rst_vga", {20'd0, vga_data}, 0);

        // Place coinciding with expiry: place wins, no expired pulse
        place(3'd2, 5'd0, 5'd0, 1'b0);
        frame_tick = 1'b1;
        for (int k = 0; k < 9; k++) step();
        place_req = 1'b1;
        #1;
        chk("place_expiry_pulse", {31'd0, expired}, 0);
        step();
        place_req = 1'b0; frame_tick = 1'b0;
        chk("place_expiry_active", {31'd0, active}, 1);

        // Reset coinciding with expiry: no expired pulse
        frame_tick = 1'b1;
        for (int k = 0; k < 9; k++) step();
        rst = 1'b1;
        #1;
        chk("rst_expiry_pulse", {31'd0, expired}, 0);
        step();
        rst = 1'b0; frame_tick = 1'b0;
        chk("rst_expiry_active", {31'd0, active}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
